// File: rtl/coef_ram_writer.sv
// Writable coefficient store: loads STACK_SIZE words from a valid/ready stream
// into a register file and serves them on a zero-latency combinational read port.
module coef_ram_writer #(
    parameter int STACK_SIZE = 64,
    parameter int DATA_WIDTH = 16,
    localparam int AW = $clog2(STACK_SIZE)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  load_start,
    input  logic                  load_abort,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_WIDTH-1:0] rd_data,
    output logic                  busy,
    output logic                  done,
    output logic                  coef_valid,
    output logic [AW:0]           wr_count
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [AW-1:0] LAST_ADDR = AW'(STACK_SIZE - 1);

    state_t                state_q, state_d;
    logic [AW-1:0]         ptr_q, ptr_d;
    logic [AW:0]           wr_count_q, wr_count_d;
    logic                  coef_valid_q, coef_valid_d;
    logic                  wr_en;
    logic [DATA_WIDTH-1:0] mem_q [STACK_SIZE];

    always_comb begin
        state_d      = state_q;
        ptr_d        = ptr_q;
        wr_count_d   = wr_count_q;
        coef_valid_d = coef_valid_q;
        wr_en        = 1'b0;
        case (state_q)
            IDLE: begin
                if (load_start && !load_abort) begin
                    state_d      = LOAD;
                    ptr_d        = '0;
                    wr_count_d   = '0;
                    coef_valid_d = 1'b0;
                end
            end
            LOAD: begin
                // Abort outranks a word presented in the same cycle.
                if (load_abort) begin
                    state_d = IDLE;
                end else if (in_valid) begin
                    wr_en      = 1'b1;
                    ptr_d      = ptr_q + AW'(1);
                    wr_count_d = wr_count_q + (AW+1)'(1);
                    if (ptr_q == LAST_ADDR) begin
                        state_d      = DONE;
                        coef_valid_d = 1'b1;
                    end
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            ptr_q        <= '0;
            wr_count_q   <= '0;
            coef_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            wr_count_q   <= wr_count_d;
            coef_valid_q <= coef_valid_d;
        end
    end

    // One register per word so the whole store clears on reset.
    genvar gi;
    generate
        for (gi = 0; gi < STACK_SIZE; gi++) begin : g_word
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    mem_q[gi] <= '0;
                end else if (wr_en && (ptr_q == AW'(gi))) begin
                    mem_q[gi] <= in_data;
                end
            end
        end
    endgenerate

    assign rd_data    = mem_q[rd_addr];
    assign in_ready   = (state_q == LOAD);
    assign busy       = (state_q == LOAD);
    assign done       = (state_q == DONE);
    assign coef_valid = coef_valid_q;
    assign wr_count   = wr_count_q;

endmodule

// File: tb/tb_coef_ram_writer.sv
// Directed self-checking bench for coef_ram_writer: load, throttle, abort,
// reload, async reset and read/write collision scenarios.
module tb_coef_ram_writer;

    localparam int N  = 64;
    localparam int DW = 16;
    localparam int AW = 6;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          load_start;
    logic          load_abort;
    logic [DW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          busy;
    logic          done;
    logic          coef_valid;
    logic [AW:0]   wr_count;

    int checks   = 0;
    int failures = 0;

    coef_ram_writer #(.STACK_SIZE(N), .DATA_WIDTH(DW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load_start (load_start),
        .load_abort (load_abort),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .rd_addr    (rd_addr),
        .rd_data    (rd_data),
        .busy       (busy),
        .done       (done),
        .coef_valid (coef_valid),
        .wr_count   (wr_count)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_load();
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; load_start = 0; load_abort = 0; in_valid = 0; in_data = '0; rd_addr = '0;
        #1;
        checks++;
        if ({in_ready, busy, done, coef_valid} !== 4'b0000) begin
            failures++;
            $display("FAIL reset_flags: got %b want 0000", {in_ready, busy, done, coef_valid});
        end
        checks++;
        if (wr_count !== 7'd0) begin
            failures++;
            $display("FAIL reset_wr_count: got %0d want 0", wr_count);
        end
        rd_addr = 6'd37; #1;
        checks++;
        if (rd_data !== 16'h0000) begin
            failures++;
            $display("FAIL reset_mem: got %h want 0000", rd_data);
        end
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        tick();
        $display("test_reset done");
    endtask

    task automatic test_full_load();
        start_load();
        checks++;
        if ({busy, in_ready, coef_valid} !== 3'b110) begin
            failures++;
            $display("FAIL full_enter_load: busy/ready/valid got %b want 110", {busy, in_ready, coef_valid});
        end
        in_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
            in_data = DW'(i + 1);
            tick();
            if (i == N - 2) begin
                checks++;
                if (done !== 1'b0 || wr_count !== 7'd63) begin
                    failures++;
                    $display("FAIL full_early_done: done=%b cnt=%0d want 0/63", done, wr_count);
                end
            end
        end
        checks++;
        if ({done, coef_valid, busy, in_ready} !== 4'b1100 || wr_count !== 7'd64) begin
            failures++;
            $display("FAIL full_done: done/valid/busy/ready=%b cnt=%0d want 1100/64",
                     {done, coef_valid, busy, in_ready}, wr_count);
        end
        tick();
        in_valid = 1'b0;
        checks++;
        if (done !== 1'b0 || coef_valid !== 1'b1 || wr_count !== 7'd64) begin
            failures++;
            $display("FAIL full_after_done: done=%b valid=%b cnt=%0d want 0/1/64", done, coef_valid, wr_count);
        end
        for (int a = 0; a < N; a++) begin
            rd_addr = AW'(a); #1;
            checks++;
            if (rd_data !== DW'(a + 1)) begin
                failures++;
                $display("FAIL full_read[%0d]: got %h want %h", a, rd_data, DW'(a + 1));
            end
        end
        $display("test_full_load done");
    endtask

    task automatic test_reload();
        start_load();
        checks++;
        if (coef_valid !== 1'b0) begin
            failures++;
            $display("FAIL reload_valid_drop: got %b want 0", coef_valid);
        end
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        for (int i = 0; i < N; i++) begin
            load_start = (i == 20);
            tick();
        end
        load_start = 1'b0;
        checks++;
        if (done !== 1'b1 || coef_valid !== 1'b1 || wr_count !== 7'd64) begin
            failures++;
            $display("FAIL reload_done: done=%b valid=%b cnt=%0d want 1/1/64", done, coef_valid, wr_count);
        end
        in_valid = 1'b0;
        tick();
        for (int a = 0; a < N; a++) begin
            rd_addr = AW'(a); #1;
            checks++;
            if (rd_data !== 16'hFFFF) begin
                failures++;
                $display("FAIL reload_read[%0d]: got %h want ffff", a, rd_data);
            end
        end
        $display("test_reload done");
    endtask

    task automatic test_throttled();
        int ready_low = 0;
        start_load();
        for (int i = 0; i < N; i++) begin
            in_valid = 1'b1;
            in_data  = 16'hA000 + DW'(i);
            tick();
            in_valid = 1'b0;
            if (i < N - 1) begin
                if (in_ready !== 1'b1) ready_low++;
                tick();
                if (in_ready !== 1'b1) ready_low++;
            end
        end
        checks++;
        if (ready_low != 0) begin
            failures++;
            $display("FAIL throttle_ready: in_ready low %0d times in LOAD, want 0", ready_low);
        end
        checks++;
        if (done !== 1'b1 || wr_count !== 7'd64) begin
            failures++;
            $display("FAIL throttle_done: done=%b cnt=%0d want 1/64", done, wr_count);
        end
        tick();
        for (int a = 0; a < N; a++) begin
            rd_addr = AW'(a); #1;
            checks++;
            if (rd_data !== 16'hA000 + DW'(a)) begin
                failures++;
                $display("FAIL throttle_read[%0d]: got %h want %h", a, rd_data, 16'hA000 + DW'(a));
            end
        end
        $display("test_throttled done");
    endtask

    task automatic test_abort();
        start_load();
        in_valid = 1'b1;
        in_data  = 16'h1111;
        repeat (10) tick();
        in_data    = 16'h2222;
        load_abort = 1'b1;
        tick();
        load_abort = 1'b0;
        in_valid   = 1'b0;
        checks++;
        if ({busy, in_ready, done, coef_valid} !== 4'b0000 || wr_count !== 7'd10) begin
            failures++;
            $display("FAIL abort_state: busy/ready/done/valid=%b cnt=%0d want 0000/10",
                     {busy, in_ready, done, coef_valid}, wr_count);
        end
        rd_addr = 6'd9; #1;
        checks++;
        if (rd_data !== 16'h1111) begin
            failures++;
            $display("FAIL abort_mem9: got %h want 1111", rd_data);
        end
        rd_addr = 6'd10; #1;
        checks++;
        if (rd_data !== 16'hA00A) begin
            failures++;
            $display("FAIL abort_mem10: got %h want a00a", rd_data);
        end
        tick();
        checks++;
        if (wr_count !== 7'd10 || busy !== 1'b0) begin
            failures++;
            $display("FAIL abort_hold: cnt=%0d busy=%b want 10/0", wr_count, busy);
        end
        $display("test_abort done");
    endtask

    task automatic test_collision();
        start_load();
        rd_addr  = 6'd5;
        in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            in_data = 16'h0100 + DW'(i);
            tick();
        end
        in_data = 16'h5A5A;
        #1;
        checks++;
        if (rd_data !== 16'h1111) begin
            failures++;
            $display("FAIL collide_before: got %h want 1111", rd_data);
        end
        tick();
        in_valid   = 1'b0;
        checks++;
        if (rd_data !== 16'h5A5A) begin
            failures++;
            $display("FAIL collide_after: got %h want 5a5a", rd_data);
        end
        load_abort = 1'b1;
        tick();
        load_abort = 1'b0;
        in_valid   = 1'b1;
        in_data    = 16'hBEEF;
        repeat (3) begin
            tick();
            checks++;
            if (in_ready !== 1'b0) begin
                failures++;
                $display("FAIL idle_ready: got %b want 0", in_ready);
            end
        end
        in_valid = 1'b0;
        rd_addr  = 6'd6; #1;
        checks++;
        if (rd_data !== 16'h1111 || wr_count !== 7'd6) begin
            failures++;
            $display("FAIL idle_consume: mem6=%h cnt=%0d want 1111/6", rd_data, wr_count);
        end
        $display("test_collision done");
    endtask

    task automatic test_async_reset();
        int nonzero = 0;
        start_load();
        in_valid = 1'b1;
        in_data  = 16'h3333;
        repeat (20) tick();
        #3 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, in_ready, done, coef_valid} !== 4'b0000 || wr_count !== 7'd0) begin
            failures++;
            $display("FAIL async_flags: busy/ready/done/valid=%b cnt=%0d want 0000/0",
                     {busy, in_ready, done, coef_valid}, wr_count);
        end
        in_valid = 1'b0;
        for (int a = 0; a < N; a++) begin
            rd_addr = AW'(a); #1;
            if (rd_data !== 16'h0000) nonzero++;
        end
        checks++;
        if (nonzero != 0) begin
            failures++;
            $display("FAIL async_mem: %0d nonzero words want 0", nonzero);
        end
        @(negedge clk) rst_n = 1'b1;
        tick();
        start_load();
        in_valid = 1'b1;
        for (int i = 0; i < N; i++) begin
            in_data = 16'h0700 + DW'(i);
            tick();
        end
        in_valid = 1'b0;
        checks++;
        if (done !== 1'b1 || coef_valid !== 1'b1 || wr_count !== 7'd64) begin
            failures++;
            $display("FAIL async_reload_done: done=%b valid=%b cnt=%0d want 1/1/64", done, coef_valid, wr_count);
        end
        rd_addr = 6'd63; #1;
        checks++;
        if (rd_data !== 16'h073F) begin
            failures++;
            $display("FAIL async_reload_read: got %h want 073f", rd_data);
        end
        $display("test_async_reset done");
    endtask

    initial begin
        test_reset();
        test_full_load();
        test_reload();
        test_throttled();
        test_abort();
        test_collision();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
